// File: rtl/plru_pkg.sv
// Shared types and pure PLRU helpers for the 4-way tree pseudo-LRU controller.
package plru_pkg;

    localparam int unsigned PLRU_WAYS = 4;
    localparam int unsigned PLRU_BITS = 3;

    typedef logic [2:0] plru_state_t;
    typedef logic [1:0] way_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // Bit 0 picks the half, bits 1/2 pick the way inside the lower/upper half.
    function automatic way_t plru_victim(input plru_state_t s);
        way_t v;
        v = s[0] ? {1'b1, s[2]} : {1'b0, s[1]};
        return v;
    endfunction

    // Point every tree node on the path away from the touched way.
    function automatic plru_state_t plru_touch(input plru_state_t s, input way_t w);
        plru_state_t n;
        n[0] = ~w[1];
        if (!w[1]) begin
            n[1] = ~w[0];
            n[2] = s[2];
        end else begin
            n[1] = s[1];
            n[2] = ~w[0];
        end
        return n;
    endfunction

endpackage

// File: rtl/plru_ctrl_if.sv
// Lookup / response / touch handshake between the cache controller and plru_ctrl.
interface plru_ctrl_if
    import plru_pkg::*;
#(
    parameter int unsigned S_INDEX = 4
) ();

    logic               req_valid;
    logic [S_INDEX-1:0] req_set;
    logic               req_ready;
    logic               rsp_valid;
    way_t               rsp_victim;
    logic               touch_valid;
    way_t               touch_way;

    modport master (
        output req_valid, req_set, touch_valid, touch_way,
        input  req_ready, rsp_valid, rsp_victim
    );

    modport slave (
        input  req_valid, req_set, touch_valid, touch_way,
        output req_ready, rsp_valid, rsp_victim
    );

endinterface

// File: rtl/plru_ctrl.sv
// Pseudo-LRU state array sequencer: init sweep, victim lookup, touch RMW with bypass.
// Optional statistics counters are built when PLRU_STATS_EN is defined.
module plru_ctrl
    import plru_pkg::*;
#(
    parameter int unsigned S_INDEX = 4,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned WIDTH   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    plru_ctrl_if.slave         bus,
    output logic               lru_csb0,
    output logic               lru_web0,
    output logic [S_INDEX-1:0] lru_addr0,
    output logic [WIDTH-1:0]   lru_din0,
    input  logic [WIDTH-1:0]   lru_dout0,
    output logic               lru_csb1,
    output logic               lru_web1,
    output logic [S_INDEX-1:0] lru_addr1,
    output logic [WIDTH-1:0]   lru_din1,
    output logic [31:0]        stat_lookups,
    output logic [31:0]        stat_touches
);

    localparam int unsigned NUM_SETS = 1 << S_INDEX;

    if (WAYS != PLRU_WAYS || WIDTH != PLRU_BITS) begin : g_cfg_check
        $error("plru_ctrl supports only WAYS=4 with WIDTH=3");
    end

    ctrl_state_t        state;
    logic [S_INDEX-1:0] init_cnt;
    logic               ready_q;

    logic               s1_valid;
    logic [S_INDEX-1:0] s1_set;
    logic               byp_valid;
    logic [S_INDEX-1:0] byp_set;
    plru_state_t        byp_data;

    logic               accept;
    logic               touch_fire;
    logic               bypass_hit;
    plru_state_t        cur;
    plru_state_t        nxt;

    // Init sweep FSM; RUN is terminal until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + S_INDEX'(1);
                    if (init_cnt == S_INDEX'(NUM_SETS - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    assign accept     = bus.req_valid & ready_q;
    assign touch_fire = s1_valid & bus.touch_valid;
    assign bypass_hit = byp_valid & (byp_set == s1_set);
    assign cur        = bypass_hit ? byp_data : plru_state_t'(lru_dout0);
    assign nxt        = plru_touch(cur, bus.touch_way);

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = s1_valid;
    assign bus.rsp_victim = s1_valid ? plru_victim(cur) : way_t'(0);

    // Stage-1 tracking and one-deep write bypass for same-set back-to-back lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_set    <= '0;
            byp_valid <= 1'b0;
            byp_set   <= '0;
            byp_data  <= '0;
        end else begin
            s1_valid  <= accept;
            if (accept) begin
                s1_set <= bus.req_set;
            end
            byp_valid <= touch_fire;
            if (touch_fire) begin
                byp_set  <= s1_set;
                byp_data <= nxt;
            end
        end
    end

    // The array registers its own address/control, so ports are driven in the issuing cycle.
    always_comb begin
        lru_csb0  = 1'b1;
        lru_web0  = 1'b1;
        lru_addr0 = '0;
        lru_din0  = '0;
        lru_csb1  = 1'b1;
        lru_web1  = 1'b1;
        lru_addr1 = '0;
        lru_din1  = '0;
        if (rst_n) begin
            if (accept) begin
                lru_csb0  = 1'b0;
                lru_addr0 = bus.req_set;
            end
            if (state == INIT) begin
                lru_csb1  = 1'b0;
                lru_web1  = 1'b0;
                lru_addr1 = init_cnt;
            end else if (touch_fire) begin
                lru_csb1  = 1'b0;
                lru_web1  = 1'b0;
                lru_addr1 = s1_set;
                lru_din1  = WIDTH'(nxt);
            end
        end
    end

`ifdef PLRU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_touches <= '0;
        end else begin
            if (accept) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (touch_fire) begin
                stat_touches <= stat_touches + 32'd1;
            end
        end
    end
`else
    assign stat_lookups = '0;
    assign stat_touches = '0;
`endif

endmodule

// File: tb/tb_plru_ctrl.sv
// Directed bench for plru_ctrl with a behavioural model of the registered 2-port state array.
module tb_plru_ctrl;
    import plru_pkg::*;

    localparam int unsigned S_INDEX = 4;
    localparam int unsigned WIDTH   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic               lru_csb0, lru_web0, lru_csb1, lru_web1;
    logic [S_INDEX-1:0] lru_addr0, lru_addr1;
    logic [WIDTH-1:0]   lru_din0, lru_din1, lru_dout0;
    logic [31:0]        stat_lookups, stat_touches;

    logic [WIDTH-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    plru_ctrl_if #(.S_INDEX(S_INDEX)) bus ();

    plru_ctrl #(.S_INDEX(S_INDEX), .WAYS(4), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .lru_csb0     (lru_csb0),
        .lru_web0     (lru_web0),
        .lru_addr0    (lru_addr0),
        .lru_din0     (lru_din0),
        .lru_dout0    (lru_dout0),
        .lru_csb1     (lru_csb1),
        .lru_web1     (lru_web1),
        .lru_addr1    (lru_addr1),
        .lru_din1     (lru_din1),
        .stat_lookups (stat_lookups),
        .stat_touches (stat_touches)
    );

    always #5 clk = ~clk;

    // Array model: registered read returns the pre-write contents on a same-edge collision.
    always @(posedge clk) begin
        if (!lru_csb0 && lru_web0) lru_dout0 <= mem[lru_addr0];
        if (!lru_csb1 && !lru_web1) mem[lru_addr1] <= lru_din1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int unsigned exp_lookups;
        int unsigned exp_touches;
`ifdef PLRU_STATS_EN
        exp_lookups = 10;
        exp_touches = 4;
`else
        exp_lookups = 0;
        exp_touches = 0;
`endif
        bus.req_valid   = 1'b0;
        bus.req_set     = '0;
        bus.touch_valid = 1'b0;
        bus.touch_way   = '0;

        #1 rst_n = 1'b0;
        repeat (2) cyc();
        chk("rst_ready",  32'(bus.req_ready), 32'd0);
        chk("rst_rspv",   32'(bus.rsp_valid), 32'd0);
        chk("rst_victim", 32'(bus.rsp_victim), 32'd0);
        chk("rst_csb0",   32'(lru_csb0), 32'd1);
        chk("rst_csb1",   32'(lru_csb1), 32'd1);
        chk("rst_web1",   32'(lru_web1), 32'd1);
        chk("rst_addr1",  32'(lru_addr1), 32'd0);
        chk("rst_din1",   32'(lru_din1), 32'd0);

        // Init sweep with a request held off.
        rst_n = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_set   = 4'd9;
        for (int i = 0; i < 16; i++) begin
            smp();
            chk("init_ready", 32'(bus.req_ready), 32'd0);
            chk("init_csb1",  32'(lru_csb1), 32'd0);
            chk("init_web1",  32'(lru_web1), 32'd0);
            chk("init_addr1", 32'(lru_addr1), 32'(i));
            chk("init_din1",  32'(lru_din1), 32'd0);
            chk("init_csb0",  32'(lru_csb0), 32'd1);
            cyc();
        end
        bus.req_valid = 1'b0;
        smp();
        chk("run_ready", 32'(bus.req_ready), 32'd1);
        chk("run_csb1",  32'(lru_csb1), 32'd1);
        chk("run_web0",  32'(lru_web0), 32'd1);

        // Set 3: victim 0, touch way 0 -> 011.
        cyc(); bus.req_valid = 1'b1; bus.req_set = 4'd3;
        smp();
        chk("a_csb0",  32'(lru_csb0), 32'd0);
        chk("a_addr0", 32'(lru_addr0), 32'd3);
        cyc(); bus.req_valid = 1'b0; bus.touch_valid = 1'b1; bus.touch_way = 2'd0;
        smp();
        chk("a_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("a_vict0", 32'(bus.rsp_victim), 32'd0);
        chk("a_csb1",  32'(lru_csb1), 32'd0);
        chk("a_web1",  32'(lru_web1), 32'd0);
        chk("a_addr1", 32'(lru_addr1), 32'd3);
        chk("a_din1",  32'(lru_din1), 32'h3);
        // Set 3 again: victim 2, touch way 2 -> 110.
        cyc(); bus.touch_valid = 1'b0; bus.req_valid = 1'b1; bus.req_set = 4'd3;
        smp();
        chk("a_idle_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("a_idle_csb1", 32'(lru_csb1), 32'd1);
        cyc(); bus.req_valid = 1'b0; bus.touch_valid = 1'b1; bus.touch_way = 2'd2;
        smp();
        chk("a_vict2", 32'(bus.rsp_victim), 32'd2);
        chk("a_din1b", 32'(lru_din1), 32'h6);
        cyc(); bus.touch_valid = 1'b0; bus.req_valid = 1'b1; bus.req_set = 4'd3;
        smp();
        cyc(); bus.req_valid = 1'b0;
        smp();
        chk("a_vict1",   32'(bus.rsp_victim), 32'd1);
        chk("a_notouch", 32'(lru_csb1), 32'd1);

        // Back-to-back set 5: second response must see the first touch via bypass.
        cyc(); bus.req_valid = 1'b1; bus.req_set = 4'd5;
        smp();
        cyc(); bus.touch_valid = 1'b1; bus.touch_way = 2'd1;
        smp();
        chk("b_vict0", 32'(bus.rsp_victim), 32'd0);
        chk("b_addr1", 32'(lru_addr1), 32'd5);
        chk("b_din1",  32'(lru_din1), 32'h1);
        cyc(); bus.req_valid = 1'b0; bus.touch_valid = 1'b0;
        smp();
        chk("b_rspv",   32'(bus.rsp_valid), 32'd1);
        chk("b_bypass", 32'(bus.rsp_victim), 32'd2);
        chk("b_csb1",   32'(lru_csb1), 32'd1);

        // Set 7: touch once, then two untouched lookups return the same victim.
        cyc(); bus.req_valid = 1'b1; bus.req_set = 4'd7;
        smp();
        cyc(); bus.req_valid = 1'b0; bus.touch_valid = 1'b1; bus.touch_way = 2'd1;
        smp();
        chk("c_vict0", 32'(bus.rsp_victim), 32'd0);
        chk("c_din1",  32'(lru_din1), 32'h1);
        for (int k = 0; k < 2; k++) begin
            cyc(); bus.touch_valid = 1'b0; bus.req_valid = 1'b1; bus.req_set = 4'd7;
            smp();
            cyc(); bus.req_valid = 1'b0;
            smp();
            chk("c_vict2",   32'(bus.rsp_victim), 32'd2);
            chk("c_nowrite", 32'(lru_csb1), 32'd1);
        end

        // Touch with no response in flight is ignored.
        cyc(); bus.touch_valid = 1'b1; bus.touch_way = 2'd3;
        smp();
        chk("d_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("d_csb1", 32'(lru_csb1), 32'd1);
        cyc(); bus.touch_valid = 1'b0;

        // Two more untouched lookups on fresh sets.
        bus.req_valid = 1'b1; bus.req_set = 4'd9;
        smp();
        cyc(); bus.req_set = 4'd10;
        smp();
        chk("e_vict9", 32'(bus.rsp_victim), 32'd0);
        cyc(); bus.req_valid = 1'b0;
        smp();
        chk("e_vict10", 32'(bus.rsp_victim), 32'd0);
        cyc();
        smp();
        chk("stat_lookups", stat_lookups, 32'(exp_lookups));
        chk("stat_touches", stat_touches, 32'(exp_touches));

        // Reset during the stage-1 cycle of a touch: no write, INIT restarts.
        cyc(); bus.req_valid = 1'b1; bus.req_set = 4'd3;
        smp();
        cyc(); bus.req_valid = 1'b0; bus.touch_valid = 1'b1; bus.touch_way = 2'd3;
        #1 rst_n = 1'b0;
        #1;
        chk("r_rspv",  32'(bus.rsp_valid), 32'd0);
        chk("r_csb1",  32'(lru_csb1), 32'd1);
        chk("r_ready", 32'(bus.req_ready), 32'd0);
        chk("r_stat",  stat_lookups, 32'd0);
        cyc();
        chk("r_mem3", 32'(mem[3]), 32'h6);
        rst_n = 1'b1; bus.touch_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            smp();
            chk("r_init_addr1", 32'(lru_addr1), 32'(i));
            chk("r_init_csb1",  32'(lru_csb1), 32'd0);
            cyc();
        end
        smp();
        chk("r_run_ready", 32'(bus.req_ready), 32'd1);
        cyc(); bus.req_valid = 1'b1; bus.req_set = 4'd3;
        smp();
        cyc(); bus.req_valid = 1'b0;
        smp();
        chk("r_vict_cleared", 32'(bus.rsp_victim), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
